// File: rtl/fetch_stage.sv
// fetch_stage
//   RV32I instruction-fetch stage. Owns the fetch PC (PCF) and issues
//   in-order requests to instruction memory. Each response is tagged with
//   the PC that produced it and parked in a small in-order buffer. The
//   buffer head goes to decode with a valid/ready handshake. A redirect
//   from execute flushes the buffer. Responses that were already in flight
//   are then counted off and discarded as they return.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   imem_req_*        request channel (valid/ready, addr = PCF)
//   imem_rsp_*        response channel (valid only, in request order)
//   redirect_*        new PC from execute (taken branch / jal / jalr)
//   instr_valid/ready handshake to decode
//   InstrD/PCD/PCPlus4D  instruction word, its PC and PC+4 for decode

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so that "full" and "empty" differ
  // and the entry counts drop out of plain subtraction.
  localparam int PW = AW + 1;

  logic [31:0]    pcf_q, pcf_d;
  logic [PW-1:0]  headPtr_q, headPtr_d;
  logic [PW-1:0]  tailPtr_q, tailPtr_d;
  logic [PW-1:0]  fillPtr_q, fillPtr_d;
  logic [PW-1:0]  dropCnt_q, dropCnt_d;

  logic [31:0]    entPc_q      [DEPTH];
  logic [31:0]    entPcPlus4_q [DEPTH];
  logic [31:0]    entData_q    [DEPTH];
  logic [DEPTH-1:0] entFilled_q;

  logic [PW-1:0]  allocCnt;
  logic [PW-1:0]  unfilledCnt;
  logic [PW:0]    creditSum;
  logic [AW-1:0]  headIdx, tailIdx, fillIdx;
  logic           reqFire, popFire, rspAccept, rspDrop;

  assign allocCnt    = tailPtr_q - headPtr_q;
  assign unfilledCnt = tailPtr_q - fillPtr_q;
  assign creditSum   = {1'b0, allocCnt} + {1'b0, dropCnt_q};
  assign headIdx     = headPtr_q[AW-1:0];
  assign tailIdx     = tailPtr_q[AW-1:0];
  assign fillIdx     = fillPtr_q[AW-1:0];

  // Requests need a free buffer slot. They also must not exceed DEPTH
  // outstanding responses, counting those still owed to a flushed stream.
  // Gating with rst_n keeps the request line quiet while reset is held.
  assign imem_req_valid = rst_n && !redirect_valid
                          && (allocCnt < PW'(DEPTH))
                          && (creditSum < (PW+1)'(DEPTH));
  assign imem_req_addr  = pcf_q;

  assign instr_valid = entFilled_q[headIdx] && !redirect_valid;
  assign InstrD      = entData_q[headIdx];
  assign PCD         = entPc_q[headIdx];
  assign PCPlus4D    = entPcPlus4_q[headIdx];

  assign reqFire   = imem_req_valid && imem_req_ready;
  assign popFire   = instr_valid && instr_ready;
  assign rspAccept = imem_rsp_valid && !redirect_valid && (dropCnt_q == '0);
  assign rspDrop   = imem_rsp_valid && (dropCnt_q != '0);

  // Next-state for the PC, the buffer pointers and the drop counter.
  // A redirect overrides everything else. Any response in that cycle is
  // thrown away and charged against the drop count. The unfilled entries
  // being flushed are still owed by memory, so they add to the count.
  always_comb begin
    pcf_d     = pcf_q;
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    fillPtr_d = fillPtr_q;
    dropCnt_d = dropCnt_q;
    if (redirect_valid) begin
      pcf_d     = redirect_pc & 32'hFFFF_FFFC;
      headPtr_d = '0;
      tailPtr_d = '0;
      fillPtr_d = '0;
      dropCnt_d = dropCnt_q + unfilledCnt - PW'(imem_rsp_valid);
    end else begin
      if (reqFire) begin
        pcf_d     = pcf_q + 32'd4;
        tailPtr_d = tailPtr_q + PW'(1);
      end
      if (rspAccept) begin
        fillPtr_d = fillPtr_q + PW'(1);
      end
      if (rspDrop) begin
        dropCnt_d = dropCnt_q - PW'(1);
      end
      if (popFire) begin
        headPtr_d = headPtr_q + PW'(1);
      end
    end
  end

  // State registers and buffer entries. Allocation, fill and pop always
  // touch different slots. The tail is a free slot, the fill slot is
  // allocated but still unfilled, and the head is filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q       <= RESET_PC;
      headPtr_q   <= '0;
      tailPtr_q   <= '0;
      fillPtr_q   <= '0;
      dropCnt_q   <= '0;
      entFilled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entPc_q[i]      <= '0;
        entPcPlus4_q[i] <= '0;
        entData_q[i]    <= '0;
      end
    end else begin
      pcf_q     <= pcf_d;
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      fillPtr_q <= fillPtr_d;
      dropCnt_q <= dropCnt_d;
      if (redirect_valid) begin
        entFilled_q <= '0;
      end else begin
        if (reqFire) begin
          entPc_q[tailIdx]      <= pcf_q;
          entPcPlus4_q[tailIdx] <= pcf_q + 32'd4;
        end
        if (rspAccept) begin
          entData_q[fillIdx]   <= imem_rsp_data;
          entFilled_q[fillIdx] <= 1'b1;
        end
        if (popFire) begin
          entFilled_q[headIdx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. It contains a fixed-latency instruction
//   memory model and a queue of expected deliveries. Expected PCs are pushed
//   when a fetch is accepted, and the queue is cleared on redirect.

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] InstrD, PCD, PCPlus4D;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [31:0] expQ[$];

  int          nVec = 0;
  int          nMis = 0;
  int          cycleCnt = 0;
  int          latency = 1;
  int          popCnt = 0;
  int          firstValidCycle = -1;
  logic [31:0] expAddr = RESET_PC;
  logic [31:0] firstPopPc = 32'hFFFF_FFFF;
  logic [31:0] lastPCD, lastInstrD;
  logic        lastInstrValid, lastReqValid;
  bit          found;
  bit          sawWrap;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic compare(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle checks. This is called #1 after the inputs are driven, so
  // combinational outputs have settled well before the next rising edge.
  task automatic checkOutput();
    logic [31:0] pc;
    lastPCD        = PCD;
    lastInstrD     = InstrD;
    lastInstrValid = instr_valid;
    lastReqValid   = imem_req_valid;
    if (redirect_valid) begin
      compare(imem_req_valid, 0, "reqValidOnRedirect");
      compare(instr_valid, 0, "instrValidOnRedirect");
      expQ.delete();
      expAddr    = redirect_pc & 32'hFFFF_FFFC;
      popCnt     = 0;
      firstPopPc = 32'hFFFF_FFFF;
    end else begin
      if (instr_valid && firstValidCycle < 0) firstValidCycle = cycleCnt;
      if (instr_valid && instr_ready) begin
        compare(expQ.size() > 0, 1, "popNotEmpty");
        if (expQ.size() > 0) begin
          pc = expQ.pop_front();
          compare(PCD, pc, "PCD");
          compare(InstrD, memWord(pc), "InstrD");
          compare(PCPlus4D, pc + 32'd4, "PCPlus4D");
          if (pc == 32'hFFFF_FFFC) begin
            compare(PCPlus4D, 32'h0, "wrapPlus4");
            sawWrap = 1'b1;
          end
          if (popCnt == 0) firstPopPc = PCD;
          popCnt++;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        compare(imem_req_addr, expAddr, "reqAddr");
        expQ.push_back(expAddr);
        expAddr = expAddr + 32'd4;
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge. The memory model
  // answers in order, `latency` cycles after each accepted request.
  task automatic applyStimulus(input bit reqReady, input bit instrReady,
                               input bit redir, input logic [31:0] redirPc);
    imem_req_ready = reqReady;
    instr_ready    = instrReady;
    redirect_valid = redir;
    redirect_pc    = redirPc;
    if (memQ.size() > 0 && memQ[0].due <= cycleCnt) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(memQ[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    checkOutput();
    if (imem_rsp_valid) void'(memQ.pop_front());
    if (imem_req_valid && imem_req_ready)
      memQ.push_back('{addr: imem_req_addr, due: cycleCnt + latency});
    @(posedge clk);
    @(negedge clk);
    cycleCnt++;
  endtask

  task automatic doReset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rst_n = 1'b0;
    #1;
    compare(imem_req_valid, 0, "rstReqValid");
    compare(instr_valid, 0, "rstInstrValid");
    compare(InstrD, 0, "rstInstrD");
    compare(PCD, 0, "rstPCD");
    compare(PCPlus4D, 0, "rstPCPlus4D");
    memQ.delete();
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n           = 1'b1;
    cycleCnt        = 0;
    expAddr         = RESET_PC;
    popCnt          = 0;
    firstPopPc      = 32'hFFFF_FFFF;
    firstValidCycle = -1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2;

    // Plain stream after reset with a 1-cycle memory.
    $display("[TB] stream from reset");
    doReset();
    latency = 1;
    repeat (12) applyStimulus(1, 1, 0, 32'h0);
    compare(firstValidCycle, 2, "firstValidCycle");
    compare(firstPopPc, RESET_PC, "firstPopPc");
    compare(popCnt >= 6, 1, "streamPops");

    // Decode stall. Requests stop once the buffer is full, the head holds
    // steady, and nothing is lost after release.
    $display("[TB] decode stall");
    doReset();
    latency = 1;
    repeat (4) applyStimulus(1, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 32'h0);
      if (i >= 1) begin
        compare(lastInstrValid, 1, "stallValid");
        compare(expQ.size() > 0, 1, "stallQueue");
        if (expQ.size() > 0) begin
          compare(lastPCD, expQ[0], "stallPCD");
          compare(lastInstrD, memWord(expQ[0]), "stallInstrD");
        end
      end
    end
    compare(lastReqValid, 0, "stallReqValid");
    popCnt = 0;
    repeat (10) applyStimulus(1, 1, 0, 32'h0);
    compare(popCnt >= 5, 1, "postStallPops");

    // Redirect with two requests outstanding on a 2-cycle memory.
    $display("[TB] redirect with requests in flight");
    doReset();
    latency = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (memQ.size() == 2) found = 1'b1;
      else applyStimulus(1, 1, 0, 32'h0);
    end
    compare(found, 1, "twoInFlight");
    applyStimulus(1, 1, 1, 32'h100);
    repeat (12) applyStimulus(1, 1, 0, 32'h0);
    compare(firstPopPc, 32'h100, "redirFirstPc");
    compare(popCnt > 0, 1, "redirPops");

    // Redirect coinciding with a response, then a second redirect.
    $display("[TB] back-to-back redirects");
    doReset();
    latency = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (memQ.size() == 2 && memQ[0].due <= cycleCnt) found = 1'b1;
      else applyStimulus(1, 1, 0, 32'h0);
    end
    compare(found, 1, "rspThisCycle");
    applyStimulus(1, 1, 1, 32'h100);
    applyStimulus(1, 1, 1, 32'h200);
    compare(dut.dropCnt_q, 0, "dropCntZero");
    repeat (12) applyStimulus(1, 1, 0, 32'h0);
    compare(firstPopPc, 32'h200, "redir2FirstPc");
    compare(popCnt > 0, 1, "redir2Pops");

    // Address wrap with random memory and decode stalls.
    $display("[TB] address wrap");
    doReset();
    latency = 1;
    sawWrap = 1'b0;
    applyStimulus(1, 1, 1, 32'hFFFF_FFF8);
    repeat (40) applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0, 32'h0);
    compare(sawWrap, 1, "wrapDelivered");

    // Reset asserted while the buffer holds filled entries.
    $display("[TB] mid-stream reset");
    doReset();
    latency = 1;
    repeat (6) applyStimulus(1, 1, 0, 32'h0);
    repeat (3) applyStimulus(1, 0, 0, 32'h0);
    compare(instr_valid, 1, "validBeforeReset");
    doReset();
    repeat (6) applyStimulus(1, 1, 0, 32'h0);
    compare(firstPopPc, RESET_PC, "restartPc");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
